// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types, digit indices and blank masks for the stopwatch controller
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {RUN, PAUSE, ADJUST} mode_t;
  localparam int DIG_SEC_ONE = 0;
  localparam int DIG_SEC_TEN = 1;
  localparam int DIG_MIN_ONE = 2;
  localparam int DIG_MIN_TEN = 3;
  localparam logic [3:0] BLANK_SEC = (4'b1 << DIG_SEC_ONE) | (4'b1 << DIG_SEC_TEN);
  localparam logic [3:0] BLANK_MIN = (4'b1 << DIG_MIN_ONE) | (4'b1 << DIG_MIN_TEN);
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: conditioned controls in, BCD digits / blank mask / pause flag out
// master: drives tick_1hz, tick_2hz, adj, sel, pse_pulse (and lap_pulse when STOPWATCH_LAP_EN)
// slave: drives sec_one, sec_ten, min_one, min_ten, blank, paused
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;
  logic tick_1hz, tick_2hz, adj, sel, pse_pulse;
  bcd_t sec_one, sec_ten, min_one, min_ten;
  logic [3:0] blank;
  logic paused;
`ifdef STOPWATCH_LAP_EN
  logic lap_pulse;
  modport master(output tick_1hz, tick_2hz, adj, sel, pse_pulse, lap_pulse,
                 input sec_one, sec_ten, min_one, min_ten, blank, paused);
  modport slave(input tick_1hz, tick_2hz, adj, sel, pse_pulse, lap_pulse,
                output sec_one, sec_ten, min_one, min_ten, blank, paused);
`else
  modport master(output tick_1hz, tick_2hz, adj, sel, pse_pulse,
                 input sec_one, sec_ten, min_one, min_ten, blank, paused);
  modport slave(input tick_1hz, tick_2hz, adj, sel, pse_pulse,
                output sec_one, sec_ten, min_one, min_ten, blank, paused);
`endif
endinterface

// File: rtl/stopwatch_ctrl_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping MAX -> 00 with carry_out on the wrap
// in: clk, rst_n (sync, active-low), inc, clr; out: one, ten (BCD), carry_out
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t one,
  output bcd_t ten,
  output logic carry_out
);
  localparam bcd_t MAX_ONE = bcd_t'(MAX % 10);
  localparam bcd_t MAX_TEN = bcd_t'(MAX / 10);
  bcd_t one_q, one_d, ten_q, ten_d;
  always_comb begin
    carry_out = inc && one_q == MAX_ONE && ten_q == MAX_TEN;
    one_d = (clr || carry_out) ? 4'd0 : inc ? (one_q == 4'd9 ? 4'd0 : one_q + 4'd1) : one_q;
    ten_d = (clr || carry_out) ? 4'd0 : (inc && one_q == 4'd9) ? ten_q + 4'd1 : ten_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      one_q <= 4'd0;
      ten_q <= 4'd0;
    end else begin
      one_q <= one_d;
      ten_q <= ten_d;
    end
  end
  assign one = one_q;
  assign ten = ten_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS BCD stopwatch with run/pause/adjust modes and adjust-blink mask
// in: clk, rst_n (sync, active-low), bus.slave controls; out: bus digits, blank, paused
// STOPWATCH_LAP_EN adds bus.lap_pulse: toggles a lap hold that freezes the shown digits
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input logic clk,
  input logic rst_n,
  stopwatch_ctrl_if.slave bus
);
  mode_t mode_q, mode_d;
  logic paused_q, paused_d, phase_q, phase_d;
  logic [3:0] blank_q, blank_d;
  logic sec_inc, min_inc, sec_carry, wrap_unused;
  bcd_t s1, s10, m1, m10;
  logic [15:0] live;
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(sec_inc), .clr(1'b0),
    .one(s1), .ten(s10), .carry_out(sec_carry)
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .clr(1'b0),
    .one(m1), .ten(m10), .carry_out(wrap_unused)
  );
  // paused toggles in every mode; adj overrides it for mode selection
  always_comb begin
    paused_d = paused_q ^ bus.pse_pulse;
    mode_d = bus.adj ? ADJUST : paused_d ? PAUSE : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= RUN;
      paused_q <= 1'b0;
      phase_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      mode_q <= mode_d;
      paused_q <= paused_d;
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end
  // adjust increments the selected field alone; seconds carry only feeds minutes in RUN
  always_comb begin
    sec_inc = mode_q == RUN ? bus.tick_1hz : (mode_q == ADJUST && bus.tick_2hz && bus.sel);
    min_inc = mode_q == RUN ? sec_carry : (mode_q == ADJUST && bus.tick_2hz && !bus.sel);
    phase_d = phase_q ^ bus.tick_2hz;
    blank_d = (bus.adj && phase_d) ? (bus.sel ? BLANK_SEC : BLANK_MIN) : 4'b0000;
    live = {m10, m1, s10, s1};
    bus.blank = blank_q;
    bus.paused = paused_q;
  end
`ifdef STOPWATCH_LAP_EN
  logic hold_q, hold_d;
  logic [15:0] lap_q, lap_d;
  always_comb begin
    hold_d = bus.adj ? 1'b0 : hold_q ^ bus.lap_pulse;
    lap_d = (bus.lap_pulse && !hold_q) ? live : lap_q;
    {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one} = hold_q ? lap_q : live;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      lap_q <= 16'h0000;
    end else begin
      hold_q <= hold_d;
      lap_q <= lap_d;
    end
  end
`else
  always_comb {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one} = live;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  stopwatch_ctrl_if bus();
  stopwatch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] digits();
    return {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.tick_1hz = 1'b1;
      @(negedge clk) bus.tick_1hz = 1'b0;
    end
  endtask
  task automatic tick2(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.tick_2hz = 1'b1;
      @(negedge clk) bus.tick_2hz = 1'b0;
    end
  endtask
  task automatic tick_both();
    @(negedge clk) begin bus.tick_1hz = 1'b1; bus.tick_2hz = 1'b1; end
    @(negedge clk) begin bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; end
  endtask
  task automatic pse();
    @(negedge clk) bus.pse_pulse = 1'b1;
    @(negedge clk) bus.pse_pulse = 1'b0;
  endtask
  task automatic set_adj(input logic a, input logic s);
    @(negedge clk) begin bus.adj = a; bus.sel = s; end
    @(negedge clk);
  endtask
`ifdef STOPWATCH_LAP_EN
  task automatic lap();
    @(negedge clk) bus.lap_pulse = 1'b1;
    @(negedge clk) bus.lap_pulse = 1'b0;
  endtask
`endif
  initial begin
    bus.tick_1hz = 1'b0;
    bus.tick_2hz = 1'b0;
    bus.adj = 1'b0;
    bus.sel = 1'b0;
    bus.pse_pulse = 1'b0;
`ifdef STOPWATCH_LAP_EN
    bus.lap_pulse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_digits", digits(), 16'h0000);
    chk("rst_blank", {12'h0, bus.blank}, 16'h0000);
    chk("rst_paused", {15'h0, bus.paused}, 16'h0000);
    rst_n = 1'b1;
    tick1(61);
    chk("run_61", digits(), 16'h0101);
    chk("run_blank", {12'h0, bus.blank}, 16'h0000);
    chk("run_paused", {15'h0, bus.paused}, 16'h0000);
    set_adj(1'b1, 1'b0);
    tick2(58);
    set_adj(1'b1, 1'b1);
    tick2(57);
    set_adj(1'b0, 1'b1);
    chk("preload", digits(), 16'h5958);
    tick1(1);
    chk("bcd_5959", digits(), 16'h5959);
    tick1(1);
    chk("wrap_0000", digits(), 16'h0000);
    pse();
    chk("pause_flag", {15'h0, bus.paused}, 16'h0001);
    tick1(5);
    chk("pause_hold", digits(), 16'h0000);
    chk("pause_flag2", {15'h0, bus.paused}, 16'h0001);
    pse();
    chk("resume_flag", {15'h0, bus.paused}, 16'h0000);
    tick1(3);
    chk("resume_cnt", digits(), 16'h0003);
    tick1(55);
    chk("at_0058", digits(), 16'h0058);
    set_adj(1'b1, 1'b1);
    chk("blank_on", {12'h0, bus.blank}, 16'h0003);
    tick2(1);
    chk("adj_s59", digits(), 16'h0059);
    chk("blank_off", {12'h0, bus.blank}, 16'h0000);
    tick2(1);
    chk("adj_s00", digits(), 16'h0000);
    chk("blank_on2", {12'h0, bus.blank}, 16'h0003);
    tick2(1);
    chk("adj_s01", digits(), 16'h0001);
    chk("blank_off2", {12'h0, bus.blank}, 16'h0000);
    tick2(29);
    set_adj(1'b1, 1'b0);
    tick2(59);
    chk("at_5930", digits(), 16'h5930);
    tick_both();
    chk("adj_min_wrap", digits(), 16'h0030);
    chk("blank_min", {12'h0, bus.blank}, 16'h000c);
    pse();
    chk("pse_in_adj", {15'h0, bus.paused}, 16'h0001);
    set_adj(1'b0, 1'b0);
    tick1(2);
    chk("pause_after_adj", digits(), 16'h0030);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_digits", digits(), 16'h0000);
    chk("mid_rst_paused", {15'h0, bus.paused}, 16'h0000);
    rst_n = 1'b1;
    tick_both();
    chk("run_coincident", digits(), 16'h0001);
    tick1(9);
    chk("at_0010", digits(), 16'h0010);
`ifdef STOPWATCH_LAP_EN
    lap();
    tick1(5);
    chk("lap_hold", digits(), 16'h0010);
    lap();
    chk("lap_release", digits(), 16'h0015);
`else
    tick1(5);
    chk("live_0015", digits(), 16'h0015);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
